// File: rtl/max_finder_pkg.sv
// Shared types and constants for the bit-serial 4-operand maximum finder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package max_finder_pkg;
  localparam int NUM_OPS    = 4;
  localparam int DEF_N_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/max_finder_ctrl_if.sv
// Handshake/bus bundle between the max-finder controller and its datapath/host.
// Latency: n/a (wiring only).
// Backpressure: none; start is a level request sampled by the controller in IDLE.
interface max_finder_ctrl_if
  import max_finder_pkg::*;
  ();
  logic               start;
  logic [NUM_OPS-1:0] cur_bits;
  logic               ready;
  logic               ld;
  logic               shift_en;
  logic [NUM_OPS-1:0] cand;
  logic               done;
  logic [1:0]         max_idx;
  logic               tie;

  // Controller side
  modport master (
    input  start, cur_bits,
    output ready, ld, shift_en, cand, done, max_idx, tie
  );

  // Host/datapath side
  modport slave (
    output start, cur_bits,
    input  ready, ld, shift_en, cand, done, max_idx, tie
  );
endinterface

// File: rtl/cand_resolve.sv
// Per-bit candidate elimination: next mask, single-survivor flag, winner index, tie.
// Latency: purely combinational.
// Backpressure: none.
module cand_resolve
  import max_finder_pkg::*;
  (
  input  logic [NUM_OPS-1:0] i_cand,
  input  logic [NUM_OPS-1:0] i_cur_bits,
  output logic [NUM_OPS-1:0] o_nxt,
  output logic               o_single,
  output logic [1:0]         o_max_idx,
  output logic               o_tie
);
  logic [NUM_OPS-1:0] w_live;
  logic [2:0]         w_pop;

  // Drop candidates showing a 0 only if some live candidate shows a 1; never empties the mask
  assign w_live = i_cand & i_cur_bits;
  assign o_nxt  = (w_live != '0) ? w_live : i_cand;

  // Popcount and lowest-set-bit index of the surviving mask
  always_comb begin
    w_pop     = '0;
    o_max_idx = '0;
    for (int i = NUM_OPS - 1; i >= 0; i--) begin
      if (o_nxt[i]) begin
        w_pop     = w_pop + 3'd1;
        o_max_idx = 2'(i);
      end
    end
  end

  assign o_single = (w_pop <= 3'd1);
  assign o_tie    = (w_pop > 3'd1);
endmodule

// File: rtl/max_finder_ctrl.sv
// Sequencer for the bit-serial max finder: load, MSB-first scan with early exit, done pulse.
// Latency: k+2 cycles from start sample to done, k = bit on which the search resolves.
// Backpressure: start only accepted in IDLE (ready=1); ignored in every other state.
module max_finder_ctrl
  import max_finder_pkg::*;
  #(
  parameter int N_BITS = DEF_N_BITS,
  parameter int CNT_W  = $clog2(N_BITS)
) (
  input  logic              clk,
  input  logic              rst,
  max_finder_ctrl_if.master bus
);
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_OPS-1:0] r_cand;
  logic [1:0]         r_max_idx;
  logic               r_tie;
  logic               r_ready;
  logic               r_ld;
  logic               r_shift_en;
  logic               r_done;

  logic [NUM_OPS-1:0] w_nxt;
  logic               w_single;
  logic [1:0]         w_max_idx;
  logic               w_tie;

  cand_resolve u_resolve (
    .i_cand     (r_cand),
    .i_cur_bits (bus.cur_bits),
    .o_nxt      (w_nxt),
    .o_single   (w_single),
    .o_max_idx  (w_max_idx),
    .o_tie      (w_tie)
  );

  // FSM with counter, mask and result registers; Moore outputs registered alongside the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_cand     <= '0;
      r_max_idx  <= '0;
      r_tie      <= 1'b0;
      r_ready    <= 1'b1;
      r_ld       <= 1'b0;
      r_shift_en <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_ld   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= LOAD;
            r_ready <= 1'b0;
            r_ld    <= 1'b1;
          end
        end
        LOAD: begin
          r_cand     <= '1;
          r_cnt      <= '0;
          r_state    <= SCAN;
          r_shift_en <= 1'b1;
        end
        SCAN: begin
          r_cand <= w_nxt;
          r_cnt  <= r_cnt + CNT_W'(1);
          // Last-bit exit has priority so the counter never wraps
          if (w_single || (r_cnt == CNT_W'(N_BITS - 1))) begin
            r_state    <= DONE;
            r_max_idx  <= w_max_idx;
            r_tie      <= w_tie;
            r_shift_en <= 1'b0;
            r_done     <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state    <= IDLE;
          r_ready    <= 1'b1;
          r_shift_en <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready    = r_ready;
  assign bus.ld       = r_ld;
  assign bus.shift_en = r_shift_en;
  assign bus.cand     = r_cand;
  assign bus.done     = r_done;
  assign bus.max_idx  = r_max_idx;
  assign bus.tie      = r_tie;
endmodule

// File: tb/tb_max_finder_ctrl.sv
// Directed bench for max_finder_ctrl with a behavioural operand shift-register datapath.
// Inputs driven and outputs sampled on the falling edge.
// Every check is an immediate assertion; failures are counted and reported.
module tb_max_finder_ctrl;
  import max_finder_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  max_finder_ctrl_if bus_if ();

  max_finder_ctrl #(.N_BITS(8)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus_if.master)
  );

  always #5 clk = ~clk;

  // Datapath model: operands loaded on ld, shifted left on shift_en
  logic [7:0] op [4];
  logic [7:0] sr [4];
  initial begin
    for (int i = 0; i < 4; i++) begin
      op[i] = 8'h00;
      sr[i] = 8'h00;
    end
  end
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus_if.ld)            sr[i] <= op[i];
      else if (bus_if.shift_en) sr[i] <= sr[i] << 1;
    end
  end
  assign bus_if.cur_bits = {sr[3][7], sr[2][7], sr[1][7], sr[0][7]};

  int vecs  = 0;
  int fails = 0;

  // Per-cycle history of one run, index = falling edges since start was driven
  logic [3:0] h_cand  [0:16];
  logic       h_ld    [0:16];
  logic       h_done  [0:16];
  logic       h_ready [0:16];
  logic [1:0] h_idx   [0:16];
  logic       h_tie   [0:16];
  int lat, nld, nsh, ndone;
  logic [1:0] res_idx;
  logic       res_tie;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input logic [7:0] a3, input logic [7:0] a2,
                         input logic [7:0] a1, input logic [7:0] a0);
    op[3] = a3; op[2] = a2; op[1] = a1; op[0] = a0;
  endtask

  // Issue one start pulse (plus optional stray pulse at cycle pulse_at) and record 14 cycles
  task automatic run_search(input int pulse_at);
    lat = -1; nld = 0; nsh = 0; ndone = 0; res_idx = 2'bxx; res_tie = 1'bx;
    bus_if.start = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n == 1)            bus_if.start = 1'b0;
      if (n == pulse_at)     bus_if.start = 1'b1;
      if (n == pulse_at + 1) bus_if.start = 1'b0;
      h_cand[n] = bus_if.cand;
      h_ld[n]   = bus_if.ld;
      if (bus_if.ld)       nld++;
      if (bus_if.shift_en) nsh++;
      if (bus_if.done) begin
        ndone++;
        if (lat < 0) begin
          lat     = n;
          res_idx = bus_if.max_idx;
          res_tie = bus_if.tie;
        end
      end
    end
  endtask

  initial begin
    bus_if.start = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_ready",    32'(bus_if.ready),    32'd1);
    chk("rst_ld",       32'(bus_if.ld),       32'd0);
    chk("rst_shift_en", 32'(bus_if.shift_en), 32'd0);
    chk("rst_done",     32'(bus_if.done),     32'd0);
    chk("rst_cand",     32'(bus_if.cand),     32'd0);
    chk("rst_max_idx",  32'(bus_if.max_idx),  32'd0);
    chk("rst_tie",      32'(bus_if.tie),      32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Early exit: only operand 0 has MSB set
    set_ops(8'h7F, 8'h20, 8'h10, 8'h80);
    run_search(0);
    chk("early_latency", 32'(lat),        32'd3);
    chk("early_ld_c1",   32'(h_ld[1]),    32'd1);
    chk("early_nld",     32'(nld),        32'd1);
    chk("early_nshift",  32'(nsh),        32'd1);
    chk("early_cand",    32'(h_cand[3]),  32'b0001);
    chk("early_idx",     32'(res_idx),    32'd0);
    chk("early_tie",     32'(res_tie),    32'd0);
    chk("early_ndone",   32'(ndone),      32'd1);

    // Full scan with elimination at bits 4, 1, 0
    set_ops(8'h11, 8'h03, 8'h13, 8'h12);
    run_search(0);
    chk("full_latency",   32'(lat),        32'd10);
    chk("full_nshift",    32'(nsh),        32'd8);
    chk("full_cand_b5",   32'(h_cand[5]),  32'b1111);
    chk("full_cand_b4",   32'(h_cand[6]),  32'b1011);
    chk("full_cand_b2",   32'(h_cand[8]),  32'b1011);
    chk("full_cand_b1",   32'(h_cand[9]),  32'b0011);
    chk("full_cand_b0",   32'(h_cand[10]), 32'b0010);
    chk("full_idx",       32'(res_idx),    32'd1);
    chk("full_tie",       32'(res_tie),    32'd0);

    // Tie: all equal 0x55
    set_ops(8'h55, 8'h55, 8'h55, 8'h55);
    run_search(0);
    chk("tie55_latency", 32'(lat),        32'd10);
    chk("tie55_cand",    32'(h_cand[10]), 32'b1111);
    chk("tie55_idx",     32'(res_idx),    32'd0);
    chk("tie55_tie",     32'(res_tie),    32'd1);

    // Tie: all zero
    set_ops(8'h00, 8'h00, 8'h00, 8'h00);
    run_search(0);
    chk("tie00_latency", 32'(lat),     32'd10);
    chk("tie00_nshift",  32'(nsh),     32'd8);
    chk("tie00_idx",     32'(res_idx), 32'd0);
    chk("tie00_tie",     32'(res_tie), 32'd1);

    // Reset during the 4th SCAN cycle
    set_ops(8'h11, 8'h03, 8'h13, 8'h12);
    bus_if.start = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 1) bus_if.start = 1'b0;
    end
    chk("midrst_scanning", 32'(bus_if.shift_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready",    32'(bus_if.ready),    32'd1);
    chk("midrst_shift_en", 32'(bus_if.shift_en), 32'd0);
    chk("midrst_cand",     32'(bus_if.cand),     32'd0);
    chk("midrst_idx",      32'(bus_if.max_idx),  32'd0);
    chk("midrst_tie",      32'(bus_if.tie),      32'd0);
    ndone = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (bus_if.done) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    set_ops(8'h00, 8'h00, 8'h80, 8'h00);
    run_search(0);
    chk("postrst_latency", 32'(lat),     32'd3);
    chk("postrst_idx",     32'(res_idx), 32'd1);
    chk("postrst_tie",     32'(res_tie), 32'd0);

    // Stray start during SCAN must be ignored
    set_ops(8'h11, 8'h03, 8'h13, 8'h12);
    run_search(4);
    chk("ign_ndone",   32'(ndone),   32'd1);
    chk("ign_nld",     32'(nld),     32'd1);
    chk("ign_latency", 32'(lat),     32'd10);
    chk("ign_idx",     32'(res_idx), 32'd1);

    // Start held high across two searches
    set_ops(8'h00, 8'h80, 8'h00, 8'h00);
    bus_if.start = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (n == 4)  set_ops(8'h11, 8'h03, 8'h13, 8'h12);
      if (n == 14) bus_if.start = 1'b0;
      h_done[n]  = bus_if.done;
      h_ready[n] = bus_if.ready;
      h_ld[n]    = bus_if.ld;
      h_idx[n]   = bus_if.max_idx;
      h_tie[n]   = bus_if.tie;
    end
    chk("b2b_done1",     32'(h_done[3]),  32'd1);
    chk("b2b_idx1",      32'(h_idx[3]),   32'd2);
    chk("b2b_idle_gap",  32'(h_ready[4]), 32'd1);
    chk("b2b_reload",    32'(h_ld[5]),    32'd1);
    chk("b2b_idx_held",  32'(h_idx[13]),  32'd2);
    chk("b2b_done_gap",  32'(h_done[13]), 32'd0);
    chk("b2b_done2",     32'(h_done[14]), 32'd1);
    chk("b2b_idx2",      32'(h_idx[14]),  32'd1);
    chk("b2b_tie2",      32'(h_tie[14]),  32'd0);
    chk("b2b_no_third",  32'(h_ld[16]),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule

// File: doc/max_finder_ctrl.md
Name: max_finder_ctrl

Overview:
- Sequencing controller for the bit-serial 4-operand maximum finder.
- Commands the operand shift-register datapath to load and shift MSB-first, and owns the 4-bit candidate mask.
- Each cycle it eliminates candidates whose current bit is 0 while some other live candidate has a 1. It stops as soon as at most one candidate remains, or when the last bit has been scanned.
- Reports the winning operand index with a one-cycle done pulse.

Parameters:
- N_BITS, 8, operand width; number of bits scanned at most.
- CNT_W, $clog2(N_BITS), width of the internal bit counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a new search; sampled only in IDLE.
- cur_bits  in  4  current MSB-first bit of operands 3..0 from the datapath (bit i = operand i); valid during SCAN.
- ready  out  1  high in IDLE only.
- ld  out  1  one-cycle pulse; datapath loads operands into its shift registers.
- shift_en  out  1  high every SCAN cycle; datapath shifts left at the end of the cycle.
- cand  out  4  registered candidate mask.
- done  out  1  one-cycle pulse in DONE.
- max_idx  out  2  index of the maximum; held from DONE until the next LOAD.
- tie  out  1  high if more than one candidate survived the full scan; held like max_idx.

Behaviour:
Reset:
- Asynchronous on rst=0: state=IDLE, cand=4'b0000, bit counter=0, max_idx=0, tie=0.
- Outputs during reset: ready=1, ld=0, shift_en=0, done=0.
- Reset asserted mid-scan aborts the search. No done is issued. The datapath needs no flush; the next LOAD reinitialises it.

States IDLE, LOAD, SCAN, DONE (Moore outputs):
- IDLE: ready=1. On start=1, go to LOAD; otherwise stay.
- LOAD: ld=1 for one cycle. cand<=1111, cnt<=0. Go to SCAN.
- SCAN: shift_en=1.
  - live = cand & cur_bits.
  - nxt = (live != 0) ? live : cand. When every live candidate has a 0 bit, nothing is eliminated.
  - cand<=nxt, cnt<=cnt+1.
  - If nxt has at most one bit set, or cnt==N_BITS-1, go to DONE and register max_idx/tie from nxt. Otherwise stay in SCAN.
- DONE: done=1 for one cycle. Go to IDLE.

Result rules:
- max_idx = index of the lowest set bit of nxt.
- tie = (popcount(nxt) > 1).
- nxt can never be 0000, because elimination happens only when live != 0.

Timing and handshake:
- If start is sampled at edge E0 and the search resolves on the k-th scanned bit (1 ≤ k ≤ N_BITS), done is high in the cycle after edge E(k+1). Total latency is k+2 cycles.
- start is ignored outside IDLE. If start is held high, a new search begins on the cycle after DONE, with one IDLE cycle in between.
- The counter never wraps: the exit at cnt==N_BITS-1 takes priority over staying in SCAN.
- The early-exit check and the final-bit check can both be true in the same cycle. The result is identical either way; tie is 0 because the mask is one-hot.

Decomposition:
- Shared package max_finder_pkg holds:
  - NUM_OPS=4;
  - the state enum (IDLE, LOAD, SCAN, DONE), 2-bit encoding;
  - the default operand width.
- Sub-module cand_resolve (combinational) takes cand and cur_bits and produces nxt, single (at most one bit set), max_idx and tie.
- The FSM, counter and registers stay in max_finder_ctrl.

Test Plan:
- Early exit:
  - Stimulus: N_BITS=8, operands {3:0} = {0x7F, 0x20, 0x10, 0x80}.
  - Response: ld one cycle; after 1 SCAN cycle cand=0001; done with max_idx=0, tie=0; total latency 3 cycles.
- Full scan with elimination:
  - Stimulus: operands {0x11, 0x03, 0x13, 0x12}.
  - Response: cand goes 1111 → 1011 at bit4, holds through bit2, → 0011 at bit1, → 0010 at bit0.
  - Result: max_idx=1, tie=0, 8 SCAN cycles, done at latency 10.
- Tie:
  - Stimulus: all operands 0x55.
  - Response: cand stays 1111 for 8 SCAN cycles; max_idx=0, tie=1.
  - Repeat with all operands 0x00: same result.
- Reset mid-operation:
  - Stimulus: pull rst low during the 4th SCAN cycle.
  - Response: immediately ready=1, shift_en=0, cand=0000, max_idx=0, tie=0; no done pulse. A following start completes normally.
- Ignored start and back-to-back:
  - Stimulus: pulse start during SCAN.
  - Response: no effect; exactly one done is issued.
  - Stimulus: hold start high across two searches.
  - Response: DONE → IDLE → LOAD; second done correct; max_idx/tie held between the two done pulses.
